// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for an N:1 one-hot mux.
// A grant is held across a multi-beat packet and priority rotates past the owner on release.
module rr_onehot_arbiter #(
    parameter  int N    = 4,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            out_ready,
    input  logic            out_last,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            dbg_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_rot;
    logic [IDXW-1:0] arb_ptr;
    logic            release_beat;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_onehot;
    int              scan_idx;

    assign release_beat = grant_valid & out_ready & out_last;
    assign dbg_state    = state;

    // Arbitration always looks ahead with the rotated pointer while GRANTED,
    // so a release can hand over to the next winner on the same edge.
    always_comb begin
        ptr_rot    = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
        arb_ptr    = (state == GRANTED) ? ptr_rot : ptr;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        scan_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = (int'(arb_ptr) + k) % N;
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(scan_idx);
            end
        end
        if (win_found) begin
            win_onehot = N'(1) << win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= GRANTED;
                        grant       <= win_onehot;
                        grant_valid <= 1'b1;
                        grant_idx   <= win_idx;
                    end
                end
                GRANTED: begin
                    if (release_beat) begin
                        ptr <= ptr_rot;
                        if (win_found) begin
                            grant     <= win_onehot;
                            grant_idx <= win_idx;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_idx   <= '0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_idx   <= '0;
                end
            endcase
        end
    end

endmodule
